// File: rtl/rr_mux_pkg.sv
// Shared parameters and helpers for the round-robin arbitrating mux.
package rr_mux_pkg;

    localparam int unsigned N_DEF = 8;
    localparam int unsigned W_DEF = 16;

    // Lock state used only when RRMUX_LOCK_EN is defined.
    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with rotating priority pointer.
// Optional packet lock (IDLE/LOCKED) built only when RRMUX_LOCK_EN is defined.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic             last,
    output logic [N-1:0]     grant_c,
    output logic [SEL_W-1:0] idx_c,
    output logic [SEL_W-1:0] ptr
);

    logic [SEL_W-1:0] ptr_q;
    logic             rr_hit_c;
    logic [SEL_W-1:0] rr_idx_c;
    logic             hit_c;
    logic             step_c;

    assign ptr = ptr_q;

    // First requesting channel at or above ptr, wrapping at N.
    always_comb begin
        int unsigned      c;
        logic [SEL_W-1:0] cidx;
        rr_hit_c = 1'b0;
        rr_idx_c = '0;
        c        = 0;
        cidx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            c    = (32'(ptr_q) + k) % N;
            cidx = SEL_W'(c);
            if (!rr_hit_c && req[cidx]) begin
                rr_hit_c = 1'b1;
                rr_idx_c = cidx;
            end
        end
    end

`ifdef RRMUX_LOCK_EN
    lock_state_e      state_q;
    lock_state_e      state_d;
    logic             locked_c;
    logic [SEL_W-1:0] lock_idx_q;

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LK_IDLE;
        else        state_d_apply: state_q <= state_d;
    end

    // Lock next state: enter on a non-last beat, leave on the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LK_IDLE:   if (advance && !last) state_d = LK_LOCKED;
            LK_LOCKED: if (advance && last)  state_d = LK_IDLE;
            default:   state_d = LK_IDLE;
        endcase
    end

    // Lock outputs.
    always_comb begin
        locked_c = 1'b0;
        if (state_q == LK_LOCKED) locked_c = 1'b1;
    end

    // Remember the channel owning the packet; while locked idx_c already equals it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lock_idx_q <= '0;
        else if (advance) lock_idx_q <= idx_c;
    end

    // Locked: only the owner may win; otherwise plain round robin.
    always_comb begin
        hit_c = rr_hit_c;
        idx_c = rr_idx_c;
        if (locked_c) begin
            hit_c = req[lock_idx_q];
            idx_c = lock_idx_q;
        end
    end

    assign step_c = advance && last;
`else
    logic unused_last;
    assign unused_last = last;

    // Re-arbitrate on every beat.
    always_comb begin
        hit_c = rr_hit_c;
        idx_c = rr_idx_c;
    end

    assign step_c = advance;
`endif

    // One-hot grant from the winning index.
    always_comb begin
        grant_c = '0;
        if (hit_c) grant_c[idx_c] = 1'b1;
    end

    // Priority pointer moves just past the winner, wrapping at N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (step_c) begin
            ptr_q <= (idx_c == SEL_W'(N - 1)) ? '0 : SEL_W'(idx_c + 1'b1);
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel W-bit round-robin arbitrating mux with a registered output stage.
// Define RRMUX_LOCK_EN to hold the grant on one channel until in_last.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    logic             load_c;
    logic             accept_c;
    logic             last_c;
    logic [N-1:0]     grant_c;
    logic [SEL_W-1:0] idx_c;
    logic [SEL_W-1:0] ptr_unused;
    logic [W-1:0]     mux_data_c;

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .advance (accept_c),
        .last    (last_c),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .ptr     (ptr_unused)
    );

    // Output register free this cycle, either empty or draining.
    assign load_c   = !out_valid || out_ready;
    assign in_ready = load_c ? grant_c : '0;
    assign accept_c = load_c && (|grant_c);
    assign last_c   = in_last[idx_c];

    // Select the granted channel's data.
    always_comb begin
        mux_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_c == SEL_W'(i)) mux_data_c = in_data[i*W +: W];
        end
    end

    // Output stage: load on accept, drain when downstream takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            out_data  <= mux_data_c;
            out_sel   <= idx_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (default N=8, W=16).
module tb_rr_mux_arbiter;

    localparam int unsigned N     = 8;
    localparam int unsigned W     = 16;
    localparam int unsigned SEL_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_last;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           s;
    } beat_t;

    beat_t        q[$];
    int           checks = 0;
    int           passed = 0;
    logic [W-1:0] chd[N];

    // Reference model state
    int m_ptr      = 0;
    bit m_locked   = 0;
    int m_lock_ch  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    // Winner = valid channel with smallest forward distance from ptr.
    function automatic int model_grant(input logic [N-1:0] v);
        int best  = -1;
        int bestd = N;
        if (m_locked) return v[m_lock_ch] ? m_lock_ch : -1;
        for (int c = 0; c < N; c++) begin
            if (v[c]) begin
                int d = (c - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = c;
                end
            end
        end
        return best;
    endfunction

    function automatic void model_accept(input int g, input logic l);
`ifdef RRMUX_LOCK_EN
        if (m_locked) begin
            if (l) begin
                m_locked = 0;
                m_ptr    = (g + 1) % N;
            end
        end else if (!l) begin
            m_locked  = 1;
            m_lock_ch = g;
        end else begin
            m_ptr = (g + 1) % N;
        end
`else
        if (l) m_ptr = (g + 1) % N;
        else   m_ptr = (g + 1) % N;
`endif
    endfunction

    // One cycle: drive at negedge, check in_ready, record expected beat after the edge.
    task automatic step(input logic [N-1:0] v, input logic r, input logic [N-1:0] l);
        int          g;
        bit          load;
        bit          acc;
        logic [N-1:0] exp_rdy;
        beat_t       b;
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        in_last   = l;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = chd[i];
        #1;
        g    = model_grant(v);
        load = (q.size() == 0) || r;
        acc  = load && (g >= 0);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        if (acc) begin
            b.d = chd[g];
            b.s = g;
            q.push_back(b);
            model_accept(g, l[g]);
        end
    endtask

    // Monitor: compare presented beat against the queue head; pop on handshake.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && q.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_sel", 64'(out_sel), 64'(q[0].s));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Asynchronous reset mid-cycle; register contents must clear at once.
    task automatic mid_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        q.delete();
        m_ptr    = 0;
        m_locked = 0;
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] tbl[N];
        tbl = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                16'h5678, 16'h6789, 16'h7890, 16'h8901};
        for (int i = 0; i < N; i++) chd[i] = tbl[i];
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_out_data", 64'(out_data), 64'd0);
        chk("init_out_sel", 64'(out_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin over all channels from ptr 0
        repeat (9) step('1, 1'b1, '0);
        // Backpressure with everything valid, then no-bubble resume
        repeat (3) step('1, 1'b0, '0);
        step('1, 1'b1, '0);
        repeat (2) step('0, 1'b1, '0);
        // Single request on channel 3
        step(8'b0000_1000, 1'b1, '0);
        repeat (2) step('0, 1'b1, '0);
        // Move ptr to 3, then wrap/skip between channels 2 and 5
        step(8'b0000_0100, 1'b1, '0);
        step(8'b0010_0100, 1'b1, '0);
        step(8'b0010_0100, 1'b1, '0);
        repeat (2) step('0, 1'b1, '0);
        // Packet from ch1 (last=0,0,1) competing with ch0
        step(8'b0000_0001, 1'b1, 8'b0000_0001);
        step(8'b0000_0011, 1'b1, 8'b0000_0000);
        step(8'b0000_0011, 1'b1, 8'b0000_0000);
        step(8'b0000_0011, 1'b1, 8'b0000_0010);
        step(8'b0000_0011, 1'b1, 8'b0000_0011);
        repeat (2) step('0, 1'b1, '0);
        // Reset while a beat is held under backpressure
        step('1, 1'b1, '1);
        step('1, 1'b0, '1);
        mid_reset();
        step(8'b1000_0001, 1'b1, '1);
        step('0, 1'b1, '0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) chd[i] = W'($urandom);
            step(N'($urandom), ($urandom_range(0, 3) != 0), N'($urandom));
        end
        repeat (4) step('0, 1'b1, '1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
